// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath widths and the fetch buffer entry.
package riscv_pkg;

    localparam int unsigned ADDR_WIDTH    = 64;
    localparam int unsigned INST_WIDTH    = 32;
    localparam int unsigned WORD_SIZE_POW = 2;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(1) << WORD_SIZE_POW;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(PC_STEP - ADDR_WIDTH'(1));

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch buffer of 2^DEPTH_POW entries; flush empties it in one cycle.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH_POW = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_POW;

    fetch_entry_t           r_mem [DEPTH];
    logic [DEPTH_POW-1:0]   r_wr_ptr;
    logic [DEPTH_POW-1:0]   r_rd_ptr;
    logic [DEPTH_POW:0]     r_count;

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (DEPTH_POW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

    always_ff @(posedge clk) begin
        if (i_push && !i_flush && !rst) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: pc sequencing and redirect, feeding a small fetch buffer.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [63:0] RESET_PC       = 64'h0,
    parameter int unsigned FIFO_DEPTH_POW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [INST_WIDTH-1:0] mem_data_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  inst_valid_o,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    input  logic                  inst_ready_i
);

    logic [ADDR_WIDTH-1:0] r_pc;
    fetch_entry_t          r_last;
    fetch_entry_t          w_head;
    fetch_entry_t          w_fetch;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    assign mem_addr     = r_pc;
    assign inst_valid_o = !w_empty;
    assign w_pop        = inst_valid_o && inst_ready_i;
    assign w_push       = !redirect_valid_i && (!w_full || w_pop);
    assign w_fetch      = '{pc: r_pc, inst: mem_data_i};

    // While empty the head slot may hold stale or flushed data, so present the last shown entry instead.
    assign inst_o    = inst_valid_o ? w_head.inst : r_last.inst;
    assign inst_pc_o = inst_valid_o ? w_head.pc   : r_last.pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_last <= '0;
        end else begin
            r_last <= '{pc: inst_pc_o, inst: inst_o};
            if (redirect_valid_i) begin
                r_pc <= redirect_pc_i & ALIGN_MASK;
            end else if (w_push) begin
                r_pc <= r_pc + PC_STEP;
            end
        end
    end

    fetch_fifo #(
        .DEPTH_POW (FIFO_DEPTH_POW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid_i),
        .i_data  (w_fetch),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; clk and rst are the first two ports.
REQ-002 The block SHALL have parameter RESET_PC, default 64'h0, giving the first fetch address after reset.
REQ-003 The block SHALL have parameter FIFO_DEPTH_POW, default 1, giving a fetch buffer depth of 2^FIFO_DEPTH_POW entries.
REQ-004 clk  input  1  block clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 mem_addr  output  64  byte address to instruction memory.
REQ-007 mem_data_i  input  32  instruction word returned combinationally for mem_addr in the same cycle.
REQ-008 redirect_valid_i  input  1  branch/jump redirect request.
REQ-009 redirect_pc_i  input  64  redirect target byte address.
REQ-010 inst_valid_o  output  1  buffer head holds a valid instruction.
REQ-011 inst_o  output  32  instruction at buffer head.
REQ-012 inst_pc_o  output  64  byte address of inst_o.
REQ-013 inst_ready_i  input  1  consumer accepts the head entry this cycle.

Function
REQ-014 The block SHALL hold a 64-bit pc register and drive mem_addr = pc continuously.
REQ-015 A pop SHALL occur on any cycle with inst_valid_o && inst_ready_i.
REQ-016 A push of {pc, mem_data_i} SHALL occur when !redirect_valid_i and (count < depth or pop).
REQ-017 On a push, pc SHALL advance by 4 and wrap modulo 2^64; otherwise pc SHALL hold.
REQ-018 Fetch-to-output latency SHALL be 1 cycle: an entry pushed in cycle N appears at the head in cycle N+1 if the buffer was empty.
REQ-019 The buffer SHALL be a circular FIFO; read and write pointers SHALL wrap modulo depth, and count SHALL range 0..depth.
REQ-020 Full buffer with no pop: there SHALL be no push and pc SHALL hold.
REQ-021 Full buffer with a pop: push and pop SHALL both occur and count SHALL be unchanged.
REQ-022 inst_valid_o SHALL equal (count != 0).
REQ-023 When inst_valid_o is 0, inst_o and inst_pc_o SHALL hold their last value and carry no meaning.
REQ-024 Redirect SHALL have priority over push and pop: when redirect_valid_i is 1, count and both pointers go to 0 and pc <= {redirect_pc_i[63:2], 2'b00}.
REQ-025 On redirect, inst_valid_o SHALL be 0 the next cycle.
REQ-026 On redirect, the first fetch from the target SHALL occur the next cycle, with inst_valid_o rising one cycle after that.
REQ-027 A redirect asserted on consecutive cycles SHALL have the last target win.
REQ-028 A head entry SHALL be presented unchanged until it is popped or flushed.

Reset
REQ-029 While rst is 1 the block SHALL set pc = RESET_PC, count = 0 and both pointers = 0, so that inst_valid_o = 0, inst_o = 32'h0 and inst_pc_o = 64'h0.
REQ-030 rst SHALL override redirect and handshakes.
REQ-031 rst asserted mid-stream SHALL discard all buffered entries.
REQ-032 On the first cycle after rst falls, the block SHALL fetch RESET_PC.

Structure
REQ-033 The shared package riscv_pkg SHALL hold ADDR_WIDTH=64, INST_WIDTH=32, WORD_SIZE_POW=2 and the fetch entry struct fetch_entry_t {pc, inst}.
REQ-034 The buffer SHALL be sub-module fetch_fifo, parameterized by depth, with push/pop/flush inputs and full/empty outputs.
REQ-035 Pc and redirect logic SHALL reside in instruction_fetch.

Verification
REQ-036 The bench SHALL use instruction memory preloaded with word0=32'h00000013, word1=32'h00100093, word2=32'h00200113, word3=32'h00300193 and SHALL cover scenarios REQ-037 to REQ-041.
REQ-037 Reset release with inst_ready_i=1 -> cycle 1: inst_valid_o=1, inst_pc_o=0x0, inst_o=32'h00000013; cycle 2: inst_pc_o=0x4, inst_o=32'h00100093; one instruction per cycle thereafter.
REQ-038 Hold inst_ready_i=0 for 5 cycles -> count saturates at 2, mem_addr holds at 0x8, head stays pc 0x0; on release, pcs 0x0, 0x4, 0x8 are delivered back-to-back with no gaps or duplicates.
REQ-039 redirect_pc_i=0xC while buffer full -> next cycle inst_valid_o=0; following cycle inst_pc_o=0xC, inst_o=32'h00300193; pre-redirect entries are never delivered.
REQ-040 redirect_pc_i=0xE (misaligned) -> mem_addr=0xC next cycle.
REQ-041 Assert rst for 1 cycle mid-stream (count=2) -> inst_valid_o=0 the next cycle, then restart from RESET_PC=0x0.
REQ-042 Instantiate with RESET_PC=64'hFFFF_FFFF_FFFF_FFF8 and stream 3 instructions -> pcs FFF8, FFFC, then 0x0 (wrap).
